// File: rtl/mux_sel_arbiter_if.sv
// Request/select bundle between the requesters, the round-robin arbiter and the 4:1 mux.
// MUX_SEL_STATS_EN adds the grant_count statistics signal.
interface mux_sel_arbiter_if;
  logic [3:0] req;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       valid;
`ifdef MUX_SEL_STATS_EN
  logic [7:0] grant_count;
`endif

  modport master (
    output req,
    input  sel,
    input  grant,
`ifdef MUX_SEL_STATS_EN
    input  grant_count,
`endif
    input  valid
  );

  modport slave (
    input  req,
    output sel,
    output grant,
`ifdef MUX_SEL_STATS_EN
    output grant_count,
`endif
    output valid
  );
endinterface

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter with bounded dwell time that drives a 4:1 mux select.
// MUX_SEL_STATS_EN adds a saturating count of grants issued.
module mux_sel_arbiter #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned CNT_W       = 8
) (
  input logic             clk,
  input logic             rst,
  mux_sel_arbiter_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_CYCLES - 1);

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       grant_q, grant_d;
  logic             valid_q, valid_d;
  logic             new_grant;
  logic [1:0]       sel_inc;
  logic [2:0]       pick_idle, pick_next;

  // {found, index} of the first requester scanning p, p+1, p+2, p+3 (mod 4).
  function automatic logic [2:0] pick(input logic [1:0] p, input logic [3:0] r);
    logic [2:0] res;
    logic [1:0] idx;
    res = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = p + 2'(i);
      if (!res[2] && r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign sel_inc   = sel_q + 2'd1;
  assign pick_idle = pick(ptr_q, bus.req);
  assign pick_next = pick(sel_inc, bus.req);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    grant_d   = grant_q;
    valid_d   = valid_q;
    new_grant = 1'b0;
    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        grant_d = '0;
        if (pick_idle[2]) begin
          state_d   = GRANT;
          sel_d     = pick_idle[1:0];
          grant_d   = 4'b0001 << pick_idle[1:0];
          valid_d   = 1'b1;
          cnt_d     = '0;
          new_grant = 1'b1;
        end
      end
      GRANT: begin
        if (bus.req[sel_q] && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          // Owner is scanned last, so a lone requester is simply re-granted.
          ptr_d = sel_inc;
          if (pick_next[2]) begin
            sel_d     = pick_next[1:0];
            grant_d   = 4'b0001 << pick_next[1:0];
            cnt_d     = '0;
            valid_d   = 1'b1;
            new_grant = 1'b1;
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
            grant_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.sel   = sel_q;
  assign bus.grant = grant_q;
  assign bus.valid = valid_q;

`ifdef MUX_SEL_STATS_EN
  logic [7:0] grant_count_q, grant_count_d;

  always_comb begin
    grant_count_d = grant_count_q;
    if (new_grant && (grant_count_q != 8'hFF)) grant_count_d = grant_count_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) grant_count_q <= '0;
    else     grant_count_q <= grant_count_d;
  end

  assign bus.grant_count = grant_count_q;
`else
  logic unused_new_grant;
  assign unused_new_grant = new_grant;
`endif

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench for mux_sel_arbiter: HOLD_CYCLES=4 instance plus a HOLD_CYCLES=1 instance
// with req fixed at 4'b1001.
module tb_mux_sel_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mux_sel_arbiter_if bus0 ();
  mux_sel_arbiter_if bus1 ();

  mux_sel_arbiter #(.HOLD_CYCLES(4), .CNT_W(8)) u_dut0 (
    .clk(clk),
    .rst(rst),
    .bus(bus0.slave)
  );

  mux_sel_arbiter #(.HOLD_CYCLES(1), .CNT_W(8)) u_dut1 (
    .clk(clk),
    .rst(rst),
    .bus(bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Assert reset at a falling edge, load req, release at the next falling edge.
  task automatic reset_with(input logic [3:0] r);
    @(negedge clk);
    rst = 1'b1;
    bus0.req = r;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] exp_sel;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus0.req = 4'b0000;
    bus1.req = 4'b1001;

    // Reset values
    @(negedge clk);
    check("rst_sel",   {30'd0, bus0.sel}, 32'h0);
    check("rst_grant", {28'd0, bus0.grant}, 32'h0);
    check("rst_valid", {31'd0, bus0.valid}, 32'h0);
    check("rst_valid1", {31'd0, bus1.valid}, 32'h0);

    // req=1111: each channel held 4 cycles, rotating 0,1,2,3,0; HOLD=1 instance alternates 0,3
    reset_with(4'b1111);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      exp_sel = 2'((k - 1) / 4);
      check("rr_sel",   {30'd0, bus0.sel}, {30'd0, exp_sel});
      check("rr_grant", {28'd0, bus0.grant}, {28'd0, 4'b0001 << exp_sel});
      check("rr_valid", {31'd0, bus0.valid}, 32'h1);
      check("h1_sel",   {30'd0, bus1.sel}, (k % 2 == 1) ? 32'h0 : 32'h3);
      check("h1_grant", {28'd0, bus1.grant}, (k % 2 == 1) ? 32'h1 : 32'h8);
      check("h1_valid", {31'd0, bus1.valid}, 32'h1);
    end

    // Lone persistent requester on channel 2: re-granted with no bubble
    reset_with(4'b0100);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check("lone_sel",   {30'd0, bus0.sel}, 32'h2);
      check("lone_grant", {28'd0, bus0.grant}, 32'h4);
      check("lone_valid", {31'd0, bus0.valid}, 32'h1);
    end

    // req=1010: ch1 first, drop req[1] after 2 cycles -> ch3, then req=0 -> idle
    reset_with(4'b1010);
    @(negedge clk);
    check("drop_sel1", {30'd0, bus0.sel}, 32'h1);
    check("drop_grant1", {28'd0, bus0.grant}, 32'h2);
    @(negedge clk);
    check("drop_sel1b", {30'd0, bus0.sel}, 32'h1);
    bus0.req = 4'b1000;
    @(negedge clk);
    check("hand_sel",   {30'd0, bus0.sel}, 32'h3);
    check("hand_grant", {28'd0, bus0.grant}, 32'h8);
    check("hand_valid", {31'd0, bus0.valid}, 32'h1);
    bus0.req = 4'b0000;
    @(negedge clk);
    check("idle_sel",   {30'd0, bus0.sel}, 32'h3);
    check("idle_grant", {28'd0, bus0.grant}, 32'h0);
    check("idle_valid", {31'd0, bus0.valid}, 32'h0);
    @(negedge clk);
    check("idle_sel2",  {30'd0, bus0.sel}, 32'h3);
    check("idle_valid2", {31'd0, bus0.valid}, 32'h0);

    // Async reset mid-grant, then first grant after release uses ptr=0
    reset_with(4'b0100);
    @(negedge clk);
    check("mid_grant", {28'd0, bus0.grant}, 32'h4);
    #2;
    rst = 1'b1;
    #1;
    check("async_sel",   {30'd0, bus0.sel}, 32'h0);
    check("async_grant", {28'd0, bus0.grant}, 32'h0);
    check("async_valid", {31'd0, bus0.valid}, 32'h0);
    bus0.req = 4'b1111;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_grant", {28'd0, bus0.grant}, 32'h1);
    check("post_rst_sel",   {30'd0, bus0.sel}, 32'h0);

`ifdef MUX_SEL_STATS_EN
    // HOLD=1 instance issues a new grant on every edge
    reset_with(4'b0000);
    check("stats_rst", {24'd0, bus1.grant_count}, 32'h0);
    repeat (5) @(negedge clk);
    check("stats_5", {24'd0, bus1.grant_count}, 32'd5);
    repeat (295) @(negedge clk);
    check("stats_300", {24'd0, bus1.grant_count}, 32'd255);
    repeat (10) @(negedge clk);
    check("stats_sat", {24'd0, bus1.grant_count}, 32'd255);
    rst = 1'b1;
    #1;
    check("stats_clr", {24'd0, bus1.grant_count}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_sel_arbiter.md
Name: mux_sel_arbiter

Overview:
- Round-robin arbiter that sits directly upstream of the team's 4:1 single-bit mux and drives its 2-bit select.
- Four requesters compete for the mux. The block grants one at a time and presents the winner's index on sel.
- Each grant is bounded by a maximum dwell time, so no channel can starve the others.
- valid tells the downstream consumer when the mux output y is meaningful.

Parameters:
- HOLD_CYCLES, 4, maximum consecutive cycles a single grant may last; legal range 1..2**CNT_W.
- CNT_W, 8, width of the internal dwell counter.

Ports:
- clk    input   1  single clock; all state updates on the rising edge.
- rst    input   1  asynchronous, active-high reset.
- req    input   4  request lines; req[i] requests mux input i (0=a, 1=b, 2=c, 3=d).
- sel    output  2  mux select; drives the downstream mux sel directly; registered.
- grant  output  4  one-hot grant matching sel while valid=1; 4'b0000 otherwise; registered.
- valid  output  1  high while a grant is active; registered.

Behaviour:
- Reset (async, asserts immediately, releases synchronously):
  - sel=2'b00, grant=4'b0000, valid=0.
  - Priority pointer ptr=0, state=IDLE, dwell counter cnt=0.
- States:
  - IDLE: no grant. sel holds its last value.
  - GRANT: one channel owns the mux.
- Arbitration function pick(ptr, req):
  - Returns the first index i with req[i]=1, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Returns "none" if req=0.
- IDLE:
  - If req!=0 at a rising edge: state->GRANT, sel=pick(ptr,req), grant=onehot(sel), valid=1, cnt=0.
  - Latency: req sampled at edge N gives grant visible after edge N.
  - If req=0: stay in IDLE; outputs unchanged, with valid=0 and grant=0.
- GRANT, release condition: req[sel]=0, OR cnt==HOLD_CYCLES-1.
  - No release: cnt<=cnt+1; sel, grant and valid hold.
  - Release: ptr<=sel+1 (mod 4, wraps 3->0), then evaluate n=pick(sel+1, req) in the same cycle.
    - If n exists: stay in GRANT; sel=n, grant=onehot(n), cnt=0, valid stays 1. This is a back-to-back handoff with no bubble.
    - If none: state->IDLE, valid=0, grant=0, sel holds.
- Consequences of the pick order:
  - The current owner is scanned last.
  - A lone persistent requester is re-granted immediately after its dwell expires; valid never drops and cnt restarts.
- grant is always one-hot or zero, and always equals onehot(sel) when valid=1.
- Boundary conditions:
  - HOLD_CYCLES=1: every grant lasts exactly one cycle; a continuous req=1111 rotates sel every cycle.
  - cnt never exceeds HOLD_CYCLES-1.
  - Simultaneous drop of req[sel] and dwell expiry is handled as a single release.
  - Changes to req on lines other than sel during GRANT have no effect until the next release.
  - rst mid-grant: all outputs return to reset values immediately. The first grant after reset uses ptr=0.

Optional Feature:
- Macro: MUX_SEL_STATS_EN.
- Defined:
  - Adds output port grant_count (8 bits, registered, reset 0).
  - Increments by 1 on every new grant issued: the IDLE->GRANT transition and every back-to-back handoff, including a re-grant to the same channel.
  - Saturates at 8'hFF.
- Undefined:
  - Port and counter logic are absent.
  - All other behaviour is identical.

Test Plan:
- Default params, req=4'b1111 held from reset release:
  - sel sequence 00,01,10,11,00; each value held exactly 4 cycles.
  - grant 0001,0010,0100,1000,0001; valid=1 continuously from the first grant.
- req=4'b0100 held constant:
  - grant=0100, sel=10 for 4 cycles, then an immediate re-grant to channel 2.
  - valid never drops; cnt restarts at 0.
- Grant to ch1 (req=4'b1010):
  - Drop req[1] after 2 cycles -> grant=1000, sel=11 on the next edge, with no idle cycle.
  - Then req=0 -> valid=0, grant=0000, sel stays 11.
- Reset mid-grant:
  - With grant=0100, assert rst asynchronously between clock edges -> sel=00, grant=0000, valid=0 without waiting for a clock edge.
  - Release rst with req=1111 -> first grant is 0001.
- HOLD_CYCLES=1, req=4'b1001:
  - sel alternates 00,11,00,11 every cycle; valid stays 1.
- MUX_SEL_STATS_EN defined:
  - Run 5 grants -> grant_count=5.
  - Run 300 grants -> grant_count=255 and stays there.
  - rst -> grant_count=0.
